// File: rtl/ring_buffer.sv
// ring_buffer: single-clock FIFO over a circular storage array.
//
// Parameters
//   DATA_WIDTH  - word width in bits
//   BUFFER_SIZE - capacity in words (power of two, >= 2)
//
// Ports
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous reset, active low
//   wen / din  - write request and data
//   ren        - read request; the oldest word moves into dout
//   full_flag  - buffer holds BUFFER_SIZE words
//   empty_flag - buffer holds no words
//   dout       - registered read data, holds until the next accepted read
module ring_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full_flag,
    output logic                  empty_flag,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);

    logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come from the count register only, so outputs never depend
    // combinationally on the inputs.
    assign full_flag  = (count == FULL_CNT);
    assign empty_flag = (count == '0);

    // When full, a concurrent read frees the slot the write lands in.
    // When empty, a write is not forwarded to dout in the same cycle.
    assign wr_acc = wen && (!full_flag || ren);
    assign rd_acc = ren && !empty_flag;

    // Storage is not reset; nothing reads it before it has been written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                // On a full buffer with both accepted, wptr == rptr; the
                // nonblocking read still sees the old (oldest) word.
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_buffer.sv
module tb_ring_buffer;

    localparam int DW = 32;
    localparam int N  = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full_flag;
    logic          empty_flag;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    ring_buffer #(.DATA_WIDTH(DW), .BUFFER_SIZE(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .ren        (ren),
        .din        (din),
        .full_flag  (full_flag),
        .empty_flag (empty_flag),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the last word popped.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_dout = '0;
        end else begin
            bit w_ok;
            bit r_ok;
            w_ok = wen && (q.size() < N || ren);
            r_ok = ren && q.size() > 0;
            if (r_ok) m_dout = q.pop_front();
            if (w_ok) q.push_back(din);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (dout !== m_dout || empty_flag !== (q.size() == 0) ||
            full_flag !== (q.size() == N)) begin
            errors++;
            $display("FAIL model t=%0t dout=%0d exp=%0d empty=%0b exp=%0b full=%0b exp=%0b",
                     $time, dout, m_dout, empty_flag, q.size() == 0,
                     full_flag, q.size() == N);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, return 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        wen = w;
        ren = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        // Reset state
        #2;
        chk("rst_empty", {31'd0, empty_flag}, 1);
        chk("rst_full", {31'd0, full_flag}, 0);
        chk("rst_dout", dout, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset mid-stream with 3 words stored
        cyc(1, 0, 7); cyc(1, 0, 8); cyc(1, 0, 9);
        cyc(0, 1, 0);
        chk("pre_rst_dout", dout, 7);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_empty", {31'd0, empty_flag}, 1);
        chk("mid_rst_full", {31'd0, full_flag}, 0);
        chk("mid_rst_dout", dout, 0);
        cyc(0, 0, 0);
        rst = 1'b1;
        cyc(0, 1, 0);
        chk("post_rst_read_dout", dout, 0);

        // Basic order
        for (int k = 1; k <= 5; k++) cyc(1, 0, k);
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1, 0);
            chk("basic_dout", dout, (i > 5) ? 5 : i);
            if (i == 5) chk("basic_empty", {31'd0, empty_flag}, 1);
        end
        cyc(1, 0, 12); cyc(1, 0, 13);
        cyc(0, 1, 0); chk("basic_12", dout, 12);
        cyc(0, 1, 0); chk("basic_13", dout, 13);

        // Streaming
        cyc(1, 0, 1);
        for (int k = 2; k <= 5; k++) begin
            cyc(1, 1, k);
            chk("stream_dout", dout, k - 1);
            chk("stream_empty", {31'd0, empty_flag}, 0);
        end
        cyc(0, 1, 0);
        chk("stream_last", dout, 5);
        chk("stream_empty_end", {31'd0, empty_flag}, 1);

        // Full boundary
        for (int k = 0; k < N; k++) begin
            cyc(1, 0, k);
            if (k == N - 2) chk("full_before", {31'd0, full_flag}, 0);
        end
        chk("full_set", {31'd0, full_flag}, 1);
        cyc(1, 0, 999);
        chk("full_drop", {31'd0, full_flag}, 1);
        for (int k = 0; k < N; k++) begin
            cyc(0, 1, 0);
            chk("full_read", dout, k);
        end
        chk("full_drained", {31'd0, empty_flag}, 1);

        // Full with simultaneous access
        for (int k = 0; k < N; k++) cyc(1, 0, k);
        cyc(1, 1, 500);
        chk("fullrw_dout", dout, 0);
        chk("fullrw_full", {31'd0, full_flag}, 1);
        for (int k = 1; k <= N; k++) begin
            cyc(0, 1, 0);
            chk("fullrw_read", dout, (k == N) ? 500 : k);
        end
        chk("fullrw_empty", {31'd0, empty_flag}, 1);

        // Wrap-around
        idx = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 100; k++) cyc(1, 0, idx + k);
            for (int k = 0; k < 100; k++) begin
                cyc(0, 1, 0);
                chk("wrap_read", dout, idx + k);
            end
            idx += 100;
        end

        // Randomized traffic in phases of varying write/read bias, with
        // occasional asynchronous resets; the compare process checks it.
        for (int ph = 0; ph < 8; ph++) begin
            int wp;
            int rp;
            wp = (ph % 2 == 0) ? 80 : 30;
            rp = (ph % 2 == 0) ? 30 : 80;
            if (ph >= 6) begin wp = 60; rp = 60; end
            for (int c = 0; c < 500; c++) begin
                cyc($urandom_range(99) < wp, $urandom_range(99) < rp, $urandom);
                if ($urandom_range(499) == 0) begin
                    #2 rst = 1'b0;
                    #2 rst = 1'b1;
                end
            end
        end

        cyc(0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_buffer.md
# ring_buffer

Synchronous single-clock FIFO ring buffer of `BUFFER_SIZE` words of `DATA_WIDTH` bits. It decouples a producer and a consumer in the same clock domain. Storage is a circular array addressed by wrapping read and write pointers. It provides registered read data and full/empty status flags.

## Interface
- `DATA_WIDTH`, default 32: word width in bits.
- `BUFFER_SIZE`, default 128: capacity in words; must be a power of two, ≥ 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `wen`  in  1  write request; `din` is stored when accepted.
- `ren`  in  1  read request; the oldest word is popped when accepted.
- `din`  in  `DATA_WIDTH`  write data.
- `full_flag`  out  1  high when the buffer holds `BUFFER_SIZE` words.
- `empty_flag`  out  1  high when the buffer holds 0 words.
- `dout`  out  `DATA_WIDTH`  registered read data.

## Operation
- State:
  - write pointer `wptr` and read pointer `rptr`, each `$clog2(BUFFER_SIZE)` bits;
  - occupancy `count`, `$clog2(BUFFER_SIZE)+1` bits;
  - storage array;
  - `dout` register.
- Accept rules, evaluated at each rising edge:
  - Write accepted = `wen && (!full_flag || ren)`.
  - Read accepted = `ren && !empty_flag`.
  - A write while full with no read is dropped: no pointer, count or storage change.
  - A read while empty is ignored: `dout` holds its previous value and pointers are unchanged.
- Accepted write: `mem[wptr] <= din`, then `wptr <= wptr + 1`. The pointer wraps modulo `BUFFER_SIZE` by natural overflow.
- Accepted read: `dout <= mem[rptr]`, then `rptr <= rptr + 1`, wrapping the same way.
- Simultaneous `wen` and `ren`:
  - Not empty and not full: both are accepted and `count` is unchanged.
  - Empty: only the write is accepted. There is no fall-through, so `dout` is unchanged and `count` goes to 1.
  - Full: both are accepted. The read takes the oldest word, the write fills the freed slot, and `count` stays at `BUFFER_SIZE`.
- `count` update: +1 on write only, −1 on read only, unchanged on both or neither.
- `full_flag` = (`count == BUFFER_SIZE`) and `empty_flag` = (`count == 0`). Both are decoded from the `count` register only, never from the inputs.
- Reset (`rst == 0`, asynchronous, takes effect immediately, including mid-operation):
  - `wptr = rptr = 0`, `count = 0`;
  - `dout = 0`, `empty_flag = 1`, `full_flag = 0`.
  - Storage contents need not be cleared.
- Ordering: strict FIFO. Words are read in exactly the order they were accepted, across pointer wrap-around.

## Timing
- Read latency is 1 cycle. `ren` is sampled high at edge N on a non-empty buffer, and `dout` shows the word after edge N. `dout` then holds until the next accepted read or reset.
- Flags are valid after the edge that changes `count`. Example: the edge accepting the 128th write sets `full_flag`.
- A word written at edge N may be read at edge N+1 at the earliest.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive `rst=0` mid-stream with 3 words stored → immediately `empty_flag=1`, `full_flag=0`, `dout=0`. After release, a read with `ren=1` leaves `dout=0`.
- Basic order: write 1,2,3,4,5 on consecutive cycles, then `ren=1` for 6 cycles.
  - `dout` = 1,2,3,4,5 in successive cycles.
  - `empty_flag=1` after the 5th read.
  - The 6th read leaves `dout=5`.
  - Follow with writes 12,13 and two reads → `dout` = 12, then 13.
- Streaming: write 1, then `wen=ren=1` with `din`=2,3,4,5, then `ren=1` only.
  - `dout` = 1,2,3,4,5 on consecutive cycles.
  - `empty_flag=0` throughout streaming; it goes to 1 after the last read.
- Full boundary: write 0..127.
  - `full_flag=1` after the 128th write.
  - A write of 999 while full is dropped.
  - Reading 128 words returns 0..127, with `empty_flag=1` at the end.
- Full with simultaneous access: at full, `wen=ren=1` with `din=500` → `dout=0`, `full_flag` stays 1, and word 500 is read last.
- Wrap-around: three rounds of 100 writes followed by 100 reads, with data = running index → all 300 values return in order across pointer wrap.
